// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : paddle_ctrl
//  Purpose  : Vertical paddle controller for the pong core. Moves the paddle
//             on a move-tick grid with hold-to-accelerate speed ramping, an
//             auto-track mode that follows the ball, and a per-pixel
//             paddle_present flag for the pixel mux.
//  Ports    : clk            - system clock
//             reset          - synchronous, active-high reset
//             up / down      - manual move requests
//             auto_en        - 1 = follow ball_y, manual inputs ignored
//             ball_y         - ball top row
//             row / col      - current scan position
//             pos            - paddle top row
//             moving         - 1 while the direction FSM is not IDLE
//             paddle_present - scan pixel lies inside the paddle
//             hit_zone       - (PADDLE_HIT_ZONE_EN only) ball-vs-paddle zone
//  Options  : define PADDLE_HIT_ZONE_EN to add the registered hit_zone output
//  Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
  parameter int CLKS_PER_MOVE  = 250_000,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ACTIVE_COLS    = 640,
  parameter int WIDTH          = 16,
  parameter int HEIGHT         = 64,
  parameter int IS_LEFT_PADDLE = 1,
  parameter int MARGIN         = 3,
  parameter int MAX_SPEED      = 4,
  parameter int ACCEL_TICKS    = 2,
  parameter int DEADBAND       = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           up,
  input  logic                           down,
  input  logic                           auto_en,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] ball_y,
  input  logic [$clog2(ACTIVE_ROWS)-1:0] row,
  input  logic [$clog2(ACTIVE_COLS)-1:0] col,
  output logic [$clog2(ACTIVE_ROWS)-1:0] pos,
  output logic                           moving,
  output logic                           paddle_present
`ifdef PADDLE_HIT_ZONE_EN
  ,
  output logic [1:0]                     hit_zone
`endif
);

  localparam int RW     = $clog2(ACTIVE_ROWS);
  localparam int CW     = $clog2(ACTIVE_COLS);
  // Two guard bits so sums of a row value and a small constant never wrap.
  localparam int AW     = RW + 2;
  localparam int XW     = CW + 2;
  localparam int CNT_W  = $clog2(CLKS_PER_MOVE);
  localparam int SPD_W  = $clog2(MAX_SPEED + 1);
  localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [RW-1:0]    C_Y_RESET = RW'(ACTIVE_ROWS / 2 - HEIGHT / 2);
  localparam logic [AW-1:0]    C_Y_MIN   = AW'(MARGIN);
  localparam logic [AW-1:0]    C_Y_MAX   = AW'(ACTIVE_ROWS - HEIGHT - MARGIN);
  localparam logic [AW-1:0]    C_HALF_H  = AW'(HEIGHT / 2);
  localparam logic [AW-1:0]    C_HEIGHT  = AW'(HEIGHT);
  localparam logic [AW-1:0]    C_DBAND   = AW'(DEADBAND);
  localparam logic [XW-1:0]    C_X_POS   = (IS_LEFT_PADDLE != 0) ?
                                           XW'(WIDTH / 2) :
                                           XW'(ACTIVE_COLS - 1 - (WIDTH * 3 / 2));
  localparam logic [XW-1:0]    C_WIDTH   = XW'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_TOP = CNT_W'(CLKS_PER_MOVE - 1);
  localparam logic [SPD_W-1:0] C_SPD_ONE = SPD_W'(1);
  localparam logic [SPD_W-1:0] C_SPD_MAX = SPD_W'(MAX_SPEED);
  localparam logic [HOLD_W-1:0] C_HOLD_TOP = HOLD_W'(ACCEL_TICKS - 1);

  // The request decode reuses the state encoding: S_IDLE doubles as "no request".
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  state_t              w_req;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]       y_pos_q, y_pos_d;
  logic [SPD_W-1:0]    speed_q, speed_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                w_tick;
  logic                w_move;
  logic [SPD_W-1:0]    w_step;
  logic [AW-1:0]       w_y_ext;
  logic [AW-1:0]       w_ball_ext;
  logic [AW-1:0]       w_center;
  logic [AW-1:0]       w_up_lim;
  logic [AW-1:0]       w_down_sum;

  assign w_tick     = (cnt_q == C_CNT_TOP);
  assign cnt_d      = w_tick ? '0 : cnt_q + CNT_W'(1);
  assign w_y_ext    = AW'(y_pos_q);
  assign w_ball_ext = AW'(ball_y);
  assign w_center   = w_y_ext + C_HALF_H;

  // Request decode
  always_comb begin
    w_req = S_IDLE;
    if (auto_en) begin
      if (w_ball_ext + C_DBAND < w_center) begin
        w_req = S_UP;
      end else if (w_ball_ext > w_center + C_DBAND) begin
        w_req = S_DOWN;
      end
    end else begin
      if (up && !down) begin
        w_req = S_UP;
      end else if (down && !up) begin
        w_req = S_DOWN;
      end
    end
  end

  // Direction FSM, speed ramp and clamped position update
  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    hold_d     = hold_q;
    y_pos_d    = y_pos_q;
    w_move     = 1'b0;
    w_step     = '0;
    if (w_tick) begin
      if (w_req == S_IDLE) begin
        state_d = S_IDLE;
        speed_d = C_SPD_ONE;
        hold_d  = '0;
      end else if (w_req != state_q) begin
        state_d = w_req;
        speed_d = C_SPD_ONE;
        hold_d  = '0;
        w_move  = 1'b1;
        w_step  = C_SPD_ONE;
      end else begin
        // Move by the speed in force before this tick's ramp update.
        w_move = 1'b1;
        w_step = speed_q;
        if (hold_q == C_HOLD_TOP) begin
          hold_d = '0;
          if (speed_q < C_SPD_MAX) begin
            speed_d = speed_q + C_SPD_ONE;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
    end

    w_up_lim   = C_Y_MIN + AW'(w_step);
    w_down_sum = w_y_ext + AW'(w_step);
    if (w_move) begin
      if (w_req == S_UP) begin
        y_pos_d = (w_y_ext < w_up_lim) ? RW'(C_Y_MIN) : y_pos_q - RW'(w_step);
      end else begin
        y_pos_d = (w_down_sum > C_Y_MAX) ? RW'(C_Y_MAX) : RW'(w_down_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      y_pos_q <= C_Y_RESET;
      state_q <= S_IDLE;
      speed_q <= C_SPD_ONE;
      hold_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      y_pos_q <= y_pos_d;
      state_q <= state_d;
      speed_q <= speed_d;
      hold_q  <= hold_d;
    end
  end

  assign pos    = y_pos_q;
  assign moving = (state_q != S_IDLE);

  // Pixel-inside-paddle test for the pixel mux
  logic [AW-1:0] w_row_ext;
  logic [XW-1:0] w_col_ext;

  assign w_row_ext      = AW'(row);
  assign w_col_ext      = XW'(col);
  assign paddle_present = (w_row_ext >= w_y_ext) && (w_row_ext < w_y_ext + C_HEIGHT) &&
                          (w_col_ext >= C_X_POS) && (w_col_ext < C_X_POS + C_WIDTH);

`ifdef PADDLE_HIT_ZONE_EN
  // Quarter of the paddle the ball top row falls in; outside rows saturate.
  localparam int HZ_SHIFT = $clog2(HEIGHT) - 2;

  logic [1:0]    hit_zone_q, hit_zone_d;
  logic [AW-1:0] w_ball_off;

  assign w_ball_off = w_ball_ext - w_y_ext;

  always_comb begin
    hit_zone_d = 2'd0;
    if (w_ball_ext < w_y_ext) begin
      hit_zone_d = 2'd0;
    end else if (w_ball_ext >= w_y_ext + C_HEIGHT) begin
      hit_zone_d = 2'd3;
    end else begin
      hit_zone_d = 2'(w_ball_off >> HZ_SHIFT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_zone_q <= 2'd0;
    end else begin
      hit_zone_q <= hit_zone_d;
    end
  end

  assign hit_zone = hit_zone_q;
`endif

endmodule
`default_nettype wire

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised successor to the single-speed paddle. Moves a paddle vertically on a move-tick grid with hold-to-accelerate speed ramping and an auto-track mode that follows the ball's y coordinate. It also produces the per-pixel `paddle_present` flag for the pixel mux. Instantiated twice in the pong top level, once for the left paddle and once for the right.

Parameters:
- CLKS_PER_MOVE, 250_000: clocks per move tick (≥2).
- ACTIVE_ROWS, 480: visible rows.
- ACTIVE_COLS, 640: visible columns.
- WIDTH, 16: paddle width in pixels.
- HEIGHT, 64: paddle height in pixels; must be a power of 2, ≥4.
- IS_LEFT_PADDLE, 1: 1 gives x = WIDTH/2; 0 gives x = ACTIVE_COLS-1-(WIDTH*3/2).
- MARGIN, 3: top and bottom keep-out rows.
- MAX_SPEED, 4: maximum pixels moved per tick (≥1).
- ACCEL_TICKS, 2: consecutive same-direction ticks per speed increment (≥1).
- DEADBAND, 4: auto-track tolerance in rows.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- up, input, 1: manual move-up request.
- down, input, 1: manual move-down request.
- auto_en, input, 1: 1 = auto-track mode; manual inputs are ignored.
- ball_y, input, $clog2(ACTIVE_ROWS): ball top row.
- row, input, $clog2(ACTIVE_ROWS): current scan row.
- col, input, $clog2(ACTIVE_COLS): current scan column.
- pos, output, $clog2(ACTIVE_ROWS): paddle top row (y_pos).
- moving, output, 1: 1 when the state is not IDLE.
- paddle_present, output, 1: the scan pixel lies inside the paddle.

Behaviour:
- Reset (sync, active-high):
  - counter=0, y_pos=ACTIVE_ROWS/2-HEIGHT/2 (208 at defaults).
  - state=IDLE, speed=1, hold=0, moving=0.
  - Reset has priority over all other activity, including mid-move.
- Tick generation:
  - counter runs 0..CLKS_PER_MOVE-1 and wraps.
  - tick=1 in the cycle where counter==CLKS_PER_MOVE-1.
  - All state, speed and position updates happen only on tick.
- Request decode (combinational):
  - Manual mode: up&&!down gives REQ_UP; down&&!up gives REQ_DOWN; otherwise REQ_NONE.
  - Auto mode: center = y_pos+HEIGHT/2, computed at width+1 bits.
  - ball_y+DEADBAND < center gives REQ_UP; ball_y > center+DEADBAND gives REQ_DOWN; otherwise REQ_NONE.
- FSM states are IDLE, UP and DOWN. On tick:
  - REQ_NONE: go to IDLE, speed=1, hold=0, no move.
  - Request differs from the current direction (from IDLE or on reversal): enter the new state, speed=1, hold=0, move 1 pixel.
  - Request matches the current state:
    - Move by the current (pre-update) speed.
    - If hold==ACCEL_TICKS-1: speed=min(speed+1, MAX_SPEED) and hold=0.
    - Otherwise hold++.
- Clamp (computed without underflow or overflow):
  - Ymin=MARGIN, Ymax=ACTIVE_ROWS-HEIGHT-MARGIN.
  - UP: y_pos = (y_pos < Ymin+step) ? Ymin : y_pos-step.
  - DOWN: y_pos = (y_pos+step > Ymax) ? Ymax : y_pos+step.
  - Reaching a clamp does not change the state or the speed.
- Changing auto_en mid-motion takes effect at the next tick through the normal decode; no special flush.
- Outputs:
  - pos=y_pos, registered.
  - moving = (state != IDLE), registered.
  - paddle_present is combinational: row in [y_pos, y_pos+HEIGHT) and col in [x_pos, x_pos+WIDTH).
  - x_pos is a constant derived from IS_LEFT_PADDLE.

Optional Feature:
- Macro: PADDLE_HIT_ZONE_EN.
- Defined:
  - Adds output hit_zone [1:0], registered every clk.
  - Value is 0 if ball_y < y_pos, 3 if ball_y ≥ y_pos+HEIGHT, otherwise (ball_y-y_pos)>>($clog2(HEIGHT)-2).
  - Reset value is 0.
  - Used by the ball module for bounce angle.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
All scenarios use CLKS_PER_MOVE=4 and otherwise default parameters.
- Reset → pos=208, moving=0. Assert reset on the cycle of tick 3 of a held-up move → pos=208 one cycle later.
- Hold up (manual) for 6 ticks → pos sequence 207, 206, 205, 203, 201, 198; moving=1 from tick 1.
- Preload pos=5 via a long up-hold at speed 3 → pos clamps to 3 and stays at 3. Hold down long → pos saturates at 413.
- up=down=1 while moving at speed 3 → next tick: no move, IDLE, moving=0. Then up only → moves 1.
- Reversal: hold up to speed 3, then switch to down → first down tick moves +1 and speed restarts at 1.
- auto_en=1, y_pos=208, ball_y=100 → pos decreases each tick. ball_y=238 (within DEADBAND of center 240) → no move. up=1 while in auto mode is ignored.
